// File: rtl/cpu_pkg.sv
// Shared constants and the sequencer state type for the fetch PC logic.
package cpu_pkg;

    localparam int unsigned    PC_W_DEF     = 32;
    localparam logic [31:0]    RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned    PC_STEP      = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } seq_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC / pending-target selection for pc_redirect_sequencer.
// PC_ALIGN_CHECK_EN: masks target bits [1:0] and flags misaligned redirects.
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  seq_state_e      state_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] bta_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jta_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pc_plus_4_i,
    input  logic [PC_W-1:0] pend_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic [PC_W-1:0] next_pend_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic            misalign_o,
`endif
    output logic            accept_o
);

    logic [PC_W-1:0] target;

    // The branch sits in EX and is older than the jump in ID, so it wins.
    always_comb begin
        target = br_taken_i ? bta_i : jta_i;
`ifdef PC_ALIGN_CHECK_EN
        misalign_o  = 1'b0;
        if (state_i == RUN && (br_taken_i || jmp_i) && target[1:0] != 2'b00) begin
            misalign_o = 1'b1;
        end
        target[1:0] = 2'b00;
`endif
    end

    always_comb begin
        next_pc_o   = pc_i;
        next_pend_o = pend_i;
        accept_o    = 1'b0;
        unique case (state_i)
            RUN: begin
                if (br_taken_i || jmp_i) begin
                    accept_o = 1'b1;
                    if (stall_i) begin
                        next_pend_o = target;
                    end else begin
                        next_pc_o = target;
                    end
                end else if (!stall_i) begin
                    next_pc_o = pc_plus_4_i;
                end
            end
            PEND: begin
                if (!stall_i) begin
                    next_pc_o = pend_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_redirect_sequencer.sv
// Fetch PC owner: sequential/branch/jump selection, stalled-redirect buffering, IF/ID flush.
// PC_ALIGN_CHECK_EN adds misalign_o and forces redirect targets word-aligned.
module pc_redirect_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] bta_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jta_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus_4_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic            misalign_o,
`endif
    output logic            redirect_pending_o
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic            flush_q;
    logic            accept;
`ifdef PC_ALIGN_CHECK_EN
    logic            mis_d, mis_q;
`endif

    assign pc_plus_4_o = pc_q + PC_W'(PC_STEP);

    next_pc_mux #(.PC_W(PC_W)) u_mux (
        .state_i     (state_q),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .bta_i       (bta_i),
        .jmp_i       (jmp_i),
        .jta_i       (jta_i),
        .pc_i        (pc_q),
        .pc_plus_4_i (pc_plus_4_o),
        .pend_i      (pend_q),
        .next_pc_o   (pc_d),
        .next_pend_o (pend_d),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o  (mis_d),
`endif
        .accept_o    (accept)
    );

    always_comb begin
        state_d            = state_q;
        fetch_valid_o      = 1'b0;
        redirect_pending_o = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                fetch_valid_o = 1'b1;
                if (accept && stall_i) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                redirect_pending_o = 1'b1;
                if (!stall_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= accept;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
    assign misalign_o = mis_q;
`endif

    assign pc_o    = pc_q;
    assign flush_o = flush_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Directed and randomized bench for pc_redirect_sequencer against a spec-level reference model.
module tb_pc_redirect_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, br_taken_i, jmp_i;
    logic [31:0] bta_i, jta_i;
    logic [31:0] pc_o, pc_plus_4_o;
    logic        fetch_valid_o, flush_o, redirect_pending_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: what the spec says the fetch unit should be doing.
    logic [31:0] m_pc, m_pt;
    bit          m_boot, m_pend, m_flush, m_mis;

    pc_redirect_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall_i            (stall_i),
        .br_taken_i         (br_taken_i),
        .bta_i              (bta_i),
        .jmp_i              (jmp_i),
        .jta_i              (jta_i),
        .pc_o               (pc_o),
        .pc_plus_4_o        (pc_plus_4_o),
        .fetch_valid_o      (fetch_valid_o),
        .flush_o            (flush_o),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o         (misalign_o),
`endif
        .redirect_pending_o (redirect_pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pt = 32'h0;
        m_boot = 1'b1; m_pend = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit b, input logic [31:0] bt,
                              input bit j, input logic [31:0] jt);
        logic [31:0] tgt;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pend) begin
            if (!s) begin
                m_pc   = m_pt;
                m_pend = 1'b0;
            end
        end else if (b || j) begin
            tgt = b ? bt : jt;
`ifdef PC_ALIGN_CHECK_EN
            m_mis = (tgt % 4) != 0;
            tgt   = tgt - (tgt % 4);
`endif
            m_flush = 1'b1;
            if (s) begin
                m_pend = 1'b1;
                m_pt   = tgt;
            end else begin
                m_pc = tgt;
            end
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_o,        m_pc);
        chk({tag, ".pc4"},   pc_plus_4_o, m_pc + 32'd4);
        chk({tag, ".fv"},    {31'b0, fetch_valid_o},      {31'b0, !m_boot && !m_pend});
        chk({tag, ".flush"}, {31'b0, flush_o},            {31'b0, m_flush});
        chk({tag, ".pend"},  {31'b0, redirect_pending_o}, {31'b0, m_pend});
`ifdef PC_ALIGN_CHECK_EN
        chk({tag, ".mis"},   {31'b0, misalign_o},         {31'b0, m_mis});
`endif
    endtask

    // Drive inputs, take one rising edge, then compare 1 time unit later.
    task automatic cycle(input string tag, input bit s, input bit b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt);
        stall_i = s; br_taken_i = b; bta_i = bt; jmp_i = j; jta_i = jt;
        @(posedge clk);
        model_edge(s, b, bt, j, jt);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; br_taken_i = 1'b0; jmp_i = 1'b0; bta_i = '0; jta_i = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        cycle("boot", 0, 0, 0, 0, 0);
        chk("boot_pc", pc_o, 32'h0);
        cycle("seq1", 0, 0, 0, 0, 0);
        chk("seq1_pc", pc_o, 32'h4);
        cycle("seq2", 0, 0, 0, 0, 0);
        chk("seq2_pc", pc_o, 32'h8);

        cycle("br", 0, 1, 32'h100, 0, 0);
        chk("br_pc", pc_o, 32'h100);
        chk("br_flush", {31'b0, flush_o}, 32'h1);
        cycle("br_after", 0, 0, 0, 0, 0);
        chk("br_after_pc", pc_o, 32'h104);

        cycle("both", 0, 1, 32'h200, 1, 32'h300);
        chk("both_pc", pc_o, 32'h200);
        cycle("both_after", 0, 0, 0, 0, 0);

        cycle("stj1", 1, 0, 0, 1, 32'h400);
        chk("stj1_pend", {31'b0, redirect_pending_o}, 32'h1);
        cycle("stj2", 1, 0, 0, 1, 32'h400);
        chk("stj2_flush", {31'b0, flush_o}, 32'h0);
        cycle("stj3", 1, 0, 0, 1, 32'h400);
        cycle("stj_rel", 0, 0, 0, 1, 32'h400);
        chk("stj_rel_pc", pc_o, 32'h400);
        cycle("stj_after", 0, 0, 0, 0, 0);
        chk("stj_after_pc", pc_o, 32'h404);

        cycle("wrap", 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_pc4", pc_plus_4_o, 32'h0);
        cycle("wrap_seq", 0, 0, 0, 0, 0);
        chk("wrap_seq_pc", pc_o, 32'h0);

        cycle("odd", 0, 1, 32'h102, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        chk("odd_pc", pc_o, 32'h100);
        chk("odd_mis", {31'b0, misalign_o}, 32'h1);
`else
        chk("odd_pc", pc_o, 32'h102);
`endif
        cycle("odd_after", 0, 0, 0, 0, 0);

        cycle("rpend", 1, 1, 32'h500, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pend_pc", pc_o, 32'h0);
        check_all("rst_pend");
        #2;
        rst_n = 1'b1;
        cycle("reboot", 0, 1, 32'h800, 1, 32'h900);
        chk("reboot_pc", pc_o, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            cycle("rand", $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, bt,
                  $urandom_range(0, 9) == 0, jt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
- Owns the architectural fetch PC; consumer of the branch target (BTA) and jump target addresses produced in ID/EX.
- Each cycle selects the next PC: sequential PC+4, a taken branch, or a jump.
- Buffers a redirect that arrives while fetch is stalled; emits a one-cycle flush pulse so the IF/ID pipeline register discards wrong-path instructions.
- Drives PC+4 back to the target calculators, closing the loop.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC/address width; fixed 32 for MIPS, kept for reuse.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard unit holds fetch; PC must not advance.
- br_taken_i  in  1  branch resolved taken this cycle.
- bta_i  in  PC_W  branch target address.
- jmp_i  in  1  jump decoded this cycle.
- jta_i  in  PC_W  jump target address.
- pc_o  out  PC_W  current fetch address (registered).
- pc_plus_4_o  out  PC_W  pc_o + 4, combinational.
- fetch_valid_o  out  1  pc_o is a valid fetch address this cycle.
- flush_o  out  1  registered one-cycle pulse: squash IF/ID contents.
- redirect_pending_o  out  1  high while a buffered redirect awaits stall release.

Behaviour:
- Reset: asynchronous on rst_n low.
  - pc_o = RESET_PC, flush_o = 0, redirect_pending_o = 0, fetch_valid_o = 0, pending target = 0, state = BOOT.
  - A reset mid-operation discards any pending redirect.
- States:
  - BOOT: first clock after reset release. fetch_valid_o = 0, pc_o held. Always goes to RUN; redirect inputs are ignored.
  - RUN: fetch_valid_o = 1.
    - No redirect, stall_i = 0: pc_o <= pc_o + 4.
    - No redirect, stall_i = 1: pc_o holds.
    - Redirect, stall_i = 0: pc_o <= target; flush_o = 1 next cycle; stay in RUN.
    - Redirect, stall_i = 1: pending <= target; pc_o holds; flush_o = 1 next cycle; go to PEND.
  - PEND: redirect_pending_o = 1, fetch_valid_o = 0.
    - Redirect inputs are ignored; they are duplicates from held stages or wrong-path.
    - stall_i = 0: pc_o <= pending, go to RUN.
    - stall_i = 1: stay in PEND.
- Priority: br_taken_i wins over jmp_i when both are high. The branch is in EX and older than the jump in ID. The jump is dropped; it sits on the flushed path.
- flush_o: exactly one cycle per accepted redirect, asserted the cycle after capture. It is never asserted for ignored inputs.
- Arithmetic:
  - pc_plus_4_o = pc_o + 4, modulo 2^PC_W; 0xFFFF_FFFC wraps to 0x0000_0000.
  - Targets are used as given; no re-shifting.
- Latency: a redirect sampled at edge N appears on pc_o after edge N (unstalled). With stall, it appears on the edge where stall_i is first sampled low.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - Set for one cycle when an accepted redirect target has bits [1:0] != 0.
  - The captured target has bits [1:0] forced to 0.
- When undefined:
  - No port and no logic.
  - Targets are loaded unmodified.

Decomposition:
- Shared package cpu_pkg:
  - PC_W constant.
  - RESET_PC default.
  - Sequencer state enum BOOT/RUN/PEND, 2 bits.
  - Constant PC_STEP = 4.
- Sub-module: next_pc_mux, purely combinational.
  - Selects between pc+4, bta, jta and pending by state, priority and stall.
  - Alignment masking lives here under the macro.
- The top level holds state, pc, pending and flush registers.

Test Plan:
- Reset release, no stall, 4 cycles -> fetch_valid_o low for 1 cycle; pc_o sequence 0x0, 0x0, 0x4, 0x8; flush_o never high.
- br_taken_i = 1, bta_i = 0x0000_0100 for one cycle in RUN -> pc_o = 0x100 next cycle; flush_o one-cycle pulse at the same time; then 0x104.
- br_taken_i and jmp_i both high (bta 0x200, jta 0x300) -> pc_o = 0x200; exactly one flush pulse.
- stall_i = 1 for 3 cycles, jmp_i held high with jta 0x400 throughout:
  - redirect_pending_o goes high and stays for the stall.
  - Exactly one flush pulse.
  - pc_o loads 0x400 after stall drop; re-asserted jmp_i is ignored.
- pc_o forced to 0xFFFF_FFFC via redirect -> pc_plus_4_o = 0x0; next sequential pc_o = 0x0.
- With PC_ALIGN_CHECK_EN: bta 0x0000_0102 -> pc_o = 0x100, misalign_o pulses once.
- Reset asserted during PEND -> pc_o = RESET_PC immediately, redirect_pending_o = 0.
